// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point result stage.
//  - Field positions for binary32 and binary16 encodings.
//  - Canonical quiet-NaN encodings.
//  - Bit positions inside the one-hot class vector and the flag vector.
//  - The entry record held by the output FIFO.
package fp_pkg;

   localparam int SP_EXP_MSB = 30;
   localparam int SP_EXP_LSB = 23;
   localparam int SP_MAN_MSB = 22;
   localparam int HP_EXP_MSB = 14;
   localparam int HP_EXP_LSB = 10;
   localparam int HP_MAN_MSB = 9;

   localparam logic [31:0] SP_QNAN = 32'h7FC0_0000;
   localparam logic [15:0] HP_QNAN = 16'h7E00;

   // one-hot class vector {nan,inf,normal,subnormal,zero}
   localparam int CLS_ZERO = 0;
   localparam int CLS_SUB  = 1;
   localparam int CLS_NORM = 2;
   localparam int CLS_INF  = 3;
   localparam int CLS_NAN  = 4;
   localparam int CLS_W    = 5;

   // flag vector {NV,OF,UF}
   localparam int FLG_UF = 0;
   localparam int FLG_OF = 1;
   localparam int FLG_NV = 2;
   localparam int FLG_W  = 3;

   typedef struct packed {
      logic [31:0]      result;
      logic [CLS_W-1:0] cls;
      logic [FLG_W-1:0] flags;
      logic             mode_fp;
   } entry_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational classifier for a binary32 or binary16 value.
//  i_value   [31:0]  encoded value; binary16 lives in [15:0]
//  i_mode_fp         1 = binary32, 0 = binary16
//  o_class   [4:0]   one-hot {nan,inf,normal,subnormal,zero}
//  o_is_snan         value is a signalling NaN (mantissa MSB clear)
module fp_classify
   import fp_pkg::*;
(
   input  logic [31:0]      i_value,
   input  logic             i_mode_fp,
   output logic [CLS_W-1:0] o_class,
   output logic             o_is_snan
);

   logic w_exp_zero;
   logic w_exp_ones;
   logic w_man_zero;
   logic w_man_msb;
   logic w_unused_sign;

   // the sign bit never affects the class
   assign w_unused_sign = i_value[31];

   always_comb begin
      if (i_mode_fp) begin
         w_exp_zero = (i_value[SP_EXP_MSB:SP_EXP_LSB] == '0);
         w_exp_ones = &i_value[SP_EXP_MSB:SP_EXP_LSB];
         w_man_zero = (i_value[SP_MAN_MSB:0] == '0);
         w_man_msb  = i_value[SP_MAN_MSB];
      end else begin
         w_exp_zero = (i_value[HP_EXP_MSB:HP_EXP_LSB] == '0);
         w_exp_ones = &i_value[HP_EXP_MSB:HP_EXP_LSB];
         w_man_zero = (i_value[HP_MAN_MSB:0] == '0);
         w_man_msb  = i_value[HP_MAN_MSB];
      end
   end

   always_comb begin
      o_class           = '0;
      o_class[CLS_ZERO] = w_exp_zero &  w_man_zero;
      o_class[CLS_SUB]  = w_exp_zero & ~w_man_zero;
      o_class[CLS_NORM] = ~w_exp_zero & ~w_exp_ones;
      o_class[CLS_INF]  = w_exp_ones &  w_man_zero;
      o_class[CLS_NAN]  = w_exp_ones & ~w_man_zero;
   end

   assign o_is_snan = w_exp_ones & ~w_man_zero & ~w_man_msb;

endmodule

// File: rtl/fp_result_stage.sv
// Registered result stage behind the fadd datapath.
// Classifies each accepted result, derives {NV,OF,UF}, optionally
// canonicalises NaNs, and buffers the entry in a 2-deep skid FIFO.
// Also keeps sticky exception flags and a wrapping accepted-result counter.
//  clk, reset                         clock, synchronous active-high reset
//  in_valid/in_ready                  input handshake
//  in_op_a, in_op_b, in_result        fadd operands and result
//  in_mode_fp                         1 = binary32, 0 = binary16 in [15:0]
//  out_valid/out_ready                output handshake
//  out_result, out_class, out_flags   head entry (all zero when empty)
//  out_mode_fp                        mode of the head entry
//  clr_flags, fflags                  sticky flag clear / sticky flags
//  res_count                          accepted-result counter
module fp_result_stage
   import fp_pkg::*;
#(
   parameter bit CANON_NAN = 1'b1,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_op_a,
   input  logic [31:0]      in_op_b,
   input  logic [31:0]      in_result,
   input  logic             in_mode_fp,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic [CLS_W-1:0] out_class,
   output logic [FLG_W-1:0] out_flags,
   output logic             out_mode_fp,
   input  logic             clr_flags,
   output logic [FLG_W-1:0] fflags,
   output logic [CNT_W-1:0] res_count
);

   logic [CLS_W-1:0] w_cls_r;
   logic [CLS_W-1:0] w_cls_a;
   logic [CLS_W-1:0] w_cls_b;
   logic             w_unused_snan_r;
   logic             w_snan_a;
   logic             w_snan_b;
   logic [FLG_W-1:0] w_flags;
   logic [31:0]      w_result;
   entry_t           w_entry;
   entry_t           w_head;
   logic             w_push;
   logic             w_pop;

   entry_t           r_mem [2];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_count;
   logic [FLG_W-1:0] r_fflags;
   logic [CNT_W-1:0] r_res_count;

   fp_classify u_cls_result (
      .i_value   (in_result),
      .i_mode_fp (in_mode_fp),
      .o_class   (w_cls_r),
      .o_is_snan (w_unused_snan_r)
   );

   fp_classify u_cls_op_a (
      .i_value   (in_op_a),
      .i_mode_fp (in_mode_fp),
      .o_class   (w_cls_a),
      .o_is_snan (w_snan_a)
   );

   fp_classify u_cls_op_b (
      .i_value   (in_op_b),
      .i_mode_fp (in_mode_fp),
      .o_class   (w_cls_b),
      .o_is_snan (w_snan_b)
   );

   always_comb begin
      w_flags         = '0;
      w_flags[FLG_NV] = w_cls_r[CLS_NAN] | w_snan_a | w_snan_b;
      // an infinite result from infinite inputs is exact, not an overflow
      w_flags[FLG_OF] = w_cls_r[CLS_INF] & ~w_cls_a[CLS_INF] & ~w_cls_b[CLS_INF];
      w_flags[FLG_UF] = w_cls_r[CLS_SUB];
   end

   always_comb begin
      w_result = in_mode_fp ? in_result : {16'h0000, in_result[15:0]};
      if (CANON_NAN && w_cls_r[CLS_NAN]) begin
         w_result = in_mode_fp ? SP_QNAN : {16'h0000, HP_QNAN};
      end
   end

   always_comb begin
      w_entry         = '0;
      w_entry.result  = w_result;
      w_entry.cls     = w_cls_r;
      w_entry.flags   = w_flags;
      w_entry.mode_fp = in_mode_fp;
   end

   // in_ready depends only on registered occupancy, so out_ready never
   // reaches it combinationally
   assign in_ready  = (r_count != 2'd2);
   assign out_valid = (r_count != 2'd0);
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;
   assign w_head    = r_mem[r_rd_ptr];

   // storage needs no reset: nothing is visible until r_count says so
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // a clear coinciding with an accept keeps that accept's flags
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fflags    <= '0;
         r_res_count <= '0;
      end else begin
         if (w_push) begin
            r_fflags    <= (clr_flags ? '0 : r_fflags) | w_flags;
            r_res_count <= r_res_count + CNT_W'(1);
         end else if (clr_flags) begin
            r_fflags <= '0;
         end
      end
   end

   assign out_result  = out_valid ? w_head.result  : '0;
   assign out_class   = out_valid ? w_head.cls     : '0;
   assign out_flags   = out_valid ? w_head.flags   : '0;
   assign out_mode_fp = out_valid ? w_head.mode_fp : 1'b0;
   assign fflags      = r_fflags;
   assign res_count   = r_res_count;

endmodule
